// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first two's-complement subtractor computing a - b, one bit
// per clock, with a registered borrow and a start/busy/done handshake.
// Operands are captured when start is accepted (in IDLE or DONE). The result
// is registered and held until the next operation finishes.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 1)
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request a subtraction (ignored while busy)
//   a, b    minuend / subtrahend, captured on an accepted start
//   busy    high during every SHIFT cycle (exactly WIDTH cycles)
//   done    one-cycle pulse: diff/borrow were just updated
//   diff    registered result, (a - b) mod 2^WIDTH
//   borrow  registered final borrow, 1 when unsigned a < b
//
// Optional feature:
//   SERIAL_SUB_SAT_EN  when defined, diff is clamped to 0 whenever the final
//                      borrow is 1; borrow is still reported. Handshake
//                      timing is identical in both builds.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bi_q, bi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One full-subtractor cell on the current LSBs.
  logic x_bit, y_bit, d_bit, bo_bit;
  assign x_bit  = a_q[0];
  assign y_bit  = b_q[0];
  assign d_bit  = x_bit ^ y_bit ^ bi_q;
  assign bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bi_q);

  // Result register with the new difference bit shifted in at the MSB. After
  // the last bit this value is the complete result, so it also feeds diff.
  logic [WIDTH-1:0] res_shift;
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = d_bit;
    end else begin : g_res_wn
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  // Value diff takes when the operation completes.
  logic [WIDTH-1:0] diff_final;
`ifdef SERIAL_SUB_SAT_EN
  assign diff_final = bo_bit ? '0 : res_shift;
`else
  assign diff_final = res_shift;
`endif

  // Start is honoured in IDLE and in the DONE cycle (back-to-back), never
  // while bits are still being processed.
  logic accept;
  assign accept = start && (state_q != ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bi_d     = bi_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_SHIFT: begin
        res_d = res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bi_d  = bo_bit;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          diff_d   = diff_final;
          borrow_d = bo_bit;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          bi_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bi_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bi_q     <= bi_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH=8). The driver pushes the
// expected result and the cycle at which done must appear whenever it issues
// an accepted start; an independent monitor on the falling edge pops and
// compares on every done pulse, and also checks reset values, busy length and
// that diff/borrow hold between completions.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    int               due;
    int               op_a;
    int               op_b;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_prev = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain modular arithmetic on the captured operands.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input int due);
    exp_t e;
    int   full;
    full     = int'(x) - int'(y);
    e.diff   = WIDTH'(full);
    e.borrow = (x < y);
`ifdef SERIAL_SUB_SAT_EN
    if (e.borrow) e.diff = '0;
`endif
    e.due  = due;
    e.op_a = int'(x);
    e.op_b = int'(y);
    return e;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  // ---------------------------------------------------------------- monitor
  int               busy_run = 0;
  logic [WIDTH-1:0] last_diff = '0;
  logic             last_borrow = 1'b0;

  always @(negedge clk) begin
    if (rst_prev) begin
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_diff", int'(diff), 0);
      check("rst_borrow", int'(borrow), 0);
      busy_run    = 0;
      last_diff   = '0;
      last_borrow = 1'b0;
    end else if (done) begin
      exp_t e;
      check("busy_in_done", int'(busy), 0);
      check("busy_len", busy_run, WIDTH);
      busy_run = 0;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("op a=%0d b=%0d -> diff=%0d borrow=%0d (exp %0d/%0d) at cycle %0d",
                 e.op_a, e.op_b, diff, borrow, e.diff, e.borrow, cyc);
        check("diff", int'(diff), int'(e.diff));
        check("borrow", int'(borrow), int'(e.borrow));
        check("done_cycle", cyc, e.due);
      end
      last_diff   = diff;
      last_borrow = borrow;
    end else begin
      check("hold_diff", int'(diff), int'(last_diff));
      check("hold_borrow", int'(borrow), int'(last_borrow));
      if (busy) begin
        busy_run++;
        if (busy_run > WIDTH) check("busy_overrun", busy_run, WIDTH);
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // Wait (on falling edges) until the DUT can accept a start.
  task automatic wait_ready();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("ready_timeout", 1, 0);
  endtask

  // Issue one operation and return at the falling edge of its DONE cycle with
  // start low. With junk=1, start is toggled and a/b scrambled during SHIFT.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input bit junk);
    int n = 0;
    wait_ready();
    start = 1'b1;
    a     = xa;
    b     = xb;
    sb.push_back(model(xa, xb, cyc + 1 + WIDTH));
    @(negedge clk);
    while (busy && n < 50) begin
      if (junk) begin
        start = 1'($urandom);
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) check("done_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Directed cases, each followed by an idle gap.
    run_op(8'd200, 8'd55, 1'b0);  idle(2);
    run_op(8'd55, 8'd200, 1'b0);  idle(2);
    run_op(8'd0, 8'd1, 1'b0);     idle(1);
    run_op(8'hA5, 8'hA5, 1'b0);   idle(1);

    // start held and operands changing during SHIFT.
    run_op(8'd77, 8'd33, 1'b1);   idle(2);

    // Reset during SHIFT cycle 4 aborts the operation: no done expected.
    wait_ready();
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    run_op(8'd10, 8'd3, 1'b0);

    // Back-to-back: the second start lands in the DONE cycle of the first.
    idle(2);
    run_op(8'd100, 8'd20, 1'b0);
    run_op(8'd9, 8'd4, 1'b0);
    idle(2);

    // Randomized operations with random gaps, junk and edge operands.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = '1;
        default: rb = WIDTH'($urandom);
      endcase
      run_op(ra, rb, 1'($urandom));
      idle($urandom_range(0, 2));
    end

    // Drain remaining expectations.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    idle(3);
    check("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
